// File: rtl/input_conditioner_pkg.sv
// Shared constants and the button FSM state type for the input conditioner.
// Board defaults assume a 100 MHz clock; the *_SIM values keep simulations short.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE = 2'd0,
    BTN_HELD = 2'd1,
    BTN_LONG = 2'd2
  } btn_state_e;

  localparam int DEB_CYCLES_DEFAULT  = 1_000_000;    // 10 ms
  localparam int LONG_CYCLES_DEFAULT = 100_000_000;  // 1 s
  localparam int DEB_CYCLES_SIM      = 4;
  localparam int LONG_CYCLES_SIM     = 8;

endpackage

// File: rtl/input_conditioner_if.sv
// Raw board inputs and conditioned outputs of the input conditioner.
// The master side drives the pins; the slave side is the conditioner.
interface input_conditioner_if;

  logic RLSwitch;
  logic PauseSwitch;
  logic Button_mid;
  logic RLSwitch_db;
  logic PauseSwitch_db;
  logic Button_mid_db;
  logic Button_press;
  logic Button_short;
  logic Button_long;

  modport master (
    output RLSwitch, PauseSwitch, Button_mid,
    input  RLSwitch_db, PauseSwitch_db, Button_mid_db,
    input  Button_press, Button_short, Button_long
  );

  modport slave (
    input  RLSwitch, PauseSwitch, Button_mid,
    output RLSwitch_db, PauseSwitch_db, Button_mid_db,
    output Button_press, Button_short, Button_long
  );

endinterface

// File: rtl/input_conditioner_debounce_cell.sv
// Two-flop synchroniser followed by a stability filter: the output only
// follows the synchronised input after DEB_CYCLES consecutive differing samples.
module debounce_cell
  import input_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic Reset,
  input  logic din,
  output logic dout
);

  localparam int             CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= din;
      s2_q  <= s1_q;
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  // A sample matching the output clears the run, so a glitch never accumulates.
  always_comb begin
    out_d = out_q;
    cnt_d = '0;
    if (s2_q != out_q) begin
      if (cnt_q == CNT_LAST) begin
        out_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign dout = out_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces the three board inputs and turns the debounced centre button into
// press / short-release / long-hold event pulses.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
  parameter int LONG_CYCLES = LONG_CYCLES_DEFAULT
) (
  input logic                CLK,
  input logic                Reset,
  input_conditioner_if.slave io
);

  localparam int                HCNT_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(LONG_CYCLES);

  logic [2:0] raw;
  logic [2:0] db;

  assign raw = {io.Button_mid, io.PauseSwitch, io.RLSwitch};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      debounce_cell #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_cell (
        .CLK  (CLK),
        .Reset(Reset),
        .din  (raw[gi]),
        .dout (db[gi])
      );
    end
  endgenerate

  assign io.RLSwitch_db    = db[0];
  assign io.PauseSwitch_db = db[1];
  assign io.Button_mid_db  = db[2];

  btn_state_e        state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              press, short_rel, long_hold;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= BTN_IDLE;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Pulses decode only registered state and the registered debounced level,
  // so each lands in the same cycle as the db level that causes it.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    press     = 1'b0;
    short_rel = 1'b0;
    long_hold = 1'b0;
    case (state_q)
      BTN_IDLE: begin
        if (db[2]) begin
          state_d = BTN_HELD;
          hcnt_d  = HCNT_W'(1);
          press   = 1'b1;
        end
      end
      BTN_HELD: begin
        if (!db[2]) begin
          state_d   = BTN_IDLE;
          short_rel = 1'b1;
        end else if (hcnt_q == HCNT_LAST) begin
          state_d   = BTN_LONG;
          long_hold = 1'b1;
        end else if (hcnt_q != HCNT_MAX) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      BTN_LONG: begin
        if (!db[2]) begin
          state_d = BTN_IDLE;
        end
      end
      default: state_d = BTN_IDLE;
    endcase
  end

  assign io.Button_press = press;
  assign io.Button_short = short_rel;
  assign io.Button_long  = long_hold;

endmodule
